// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core store/load port and memory drain port of the store buffer
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  logic                       st_valid;
  logic [WIDTH-1:0]           st_addr;
  logic [WIDTH-1:0]           st_data;
  logic [1:0]                 st_dsize;
  logic                       st_ready;
  logic                       ld_valid;
  logic [WIDTH-1:0]           ld_addr;
  logic                       ld_hit;
  logic [WIDTH-1:0]           ld_fwd_data;
  logic                       ld_conflict;
  logic                       mem_req;
  logic [WIDTH-1:0]           mem_addr;
  logic [WIDTH-1:0]           mem_data;
  logic [1:0]                 mem_dsize;
  logic                       mem_ack;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output st_valid, st_addr, st_data, st_dsize, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_fwd_data, ld_conflict, mem_req, mem_addr,
           mem_data, mem_dsize, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_dsize, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_fwd_data, ld_conflict, mem_req, mem_addr,
           mem_data, mem_dsize, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO with in-order req/ack drain and load hazard check
// Define STORE_BUFFER_FWD_EN to forward word stores to matching loads instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [WIDTH-1:0] addrMem [DEPTH];
  logic [WIDTH-1:0] dataMem [DEPTH];
  logic [1:0]       sizeMem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, countNext;
  logic [0:0]       state, stateNext;
  logic             pushEn, popEn;

  assign pushEn    = bus.st_valid && (count < CW'(DEPTH));
  assign popEn     = (state == REQ) && bus.mem_ack;
  assign countNext = count + CW'(pushEn) - CW'(popEn);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (count != '0) stateNext = REQ;
      REQ:     if (popEn && countNext == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        addrMem[i] <= '0;
        dataMem[i] <= '0;
        sizeMem[i] <= '0;
      end
    end else begin
      if (pushEn) begin
        addrMem[tail] <= bus.st_addr;
        dataMem[tail] <= bus.st_data;
        sizeMem[tail] <= bus.st_dsize;
        tail          <= tail + PW'(1);
      end
      if (popEn) head <= head + PW'(1);
      count <= countNext;
      state <= stateNext;
    end
  end

  assign bus.st_ready  = (count < CW'(DEPTH));
  assign bus.empty     = (count == '0);
  assign bus.count     = count;
  assign bus.mem_req   = (state == REQ);
  assign bus.mem_addr  = addrMem[head];
  assign bus.mem_data  = dataMem[head];
  assign bus.mem_dsize = sizeMem[head];

  // Walk oldest to youngest so the last match seen is the youngest one.
  logic             matchAny;
  logic [PW-1:0]    idx;
`ifdef STORE_BUFFER_FWD_EN
  logic             youngWord;
  logic [WIDTH-1:0] youngData;
`endif

  always_comb begin
    matchAny = 1'b0;
    idx      = '0;
`ifdef STORE_BUFFER_FWD_EN
    youngWord = 1'b0;
    youngData = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addrMem[idx][WIDTH-1:2] == bus.ld_addr[WIDTH-1:2])) begin
        matchAny = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        youngWord = sizeMem[idx][1];
        youngData = dataMem[idx];
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign bus.ld_hit      = bus.ld_valid && matchAny && youngWord;
  assign bus.ld_fwd_data = bus.ld_hit ? youngData : '0;
  assign bus.ld_conflict = bus.ld_valid && matchAny && !youngWord;
`else
  assign bus.ld_hit      = 1'b0;
  assign bus.ld_fwd_data = '0;
  assign bus.ld_conflict = bus.ld_valid && matchAny;
`endif

  logic unusedLdLow;
  assign unusedLdLow = ^bus.ld_addr[1:0];
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer drain order, hazards and reset
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;

  store_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) sbIf ();

  store_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbIf.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } entry_t;

  entry_t expQ[$];
  int     modelCount;
  int     passed;
  int     total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  // Called just after a negedge with inputs set; models the coming posedge.
  task automatic tick();
    entry_t e;
    bit     doPush;
    bit     doPop;
    doPop  = sbIf.mem_req && sbIf.mem_ack;
    doPush = sbIf.st_valid && (modelCount < DEPTH);
    if (doPop) begin
      if (expQ.size() == 0) begin
        checkEq("sbUnderflow", 64'(expQ.size()), 64'd1);
      end else begin
        e = expQ.pop_front();
        checkEq("drainAddr", 64'(sbIf.mem_addr), 64'(e.a));
        checkEq("drainData", 64'(sbIf.mem_data), 64'(e.d));
        checkEq("drainSize", 64'(sbIf.mem_dsize), 64'(e.s));
      end
      modelCount--;
    end
    if (doPush) begin
      e.a = sbIf.st_addr;
      e.d = sbIf.st_data;
      e.s = sbIf.st_dsize;
      expQ.push_back(e);
      modelCount++;
    end
    @(posedge clk);
    @(negedge clk);
    checkEq("count", 64'(sbIf.count), 64'(modelCount));
    checkEq("stReady", 64'(sbIf.st_ready), 64'(modelCount < DEPTH));
    checkEq("empty", 64'(sbIf.empty), 64'(modelCount == 0));
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    sbIf.st_valid = 1'b1;
    sbIf.st_addr  = a;
    sbIf.st_data  = d;
    sbIf.st_dsize = s;
    tick();
    sbIf.st_valid = 1'b0;
  endtask

  task automatic drainAll();
    sbIf.mem_ack = 1'b1;
    for (int i = 0; i < 40 && modelCount != 0; i++) tick();
    checkEq("drainTimeout", 64'(sbIf.empty), 64'd1);
    checkEq("sbLeftover", 64'(expQ.size()), 64'd0);
    sbIf.mem_ack = 1'b0;
  endtask

  task automatic loadCheck(input string tag, input logic [31:0] a,
                           input logic h, input logic [31:0] fd, input logic c);
    sbIf.ld_valid = 1'b1;
    sbIf.ld_addr  = a;
    #1;
    checkEq({tag, "Hit"}, 64'(sbIf.ld_hit), 64'(h));
    checkEq({tag, "Fwd"}, 64'(sbIf.ld_fwd_data), 64'(fd));
    checkEq({tag, "Conflict"}, 64'(sbIf.ld_conflict), 64'(c));
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    modelCount    = 0;
    reset         = 1'b0;
    sbIf.st_valid = 1'b0;
    sbIf.st_addr  = '0;
    sbIf.st_data  = '0;
    sbIf.st_dsize = '0;
    sbIf.ld_valid = 1'b0;
    sbIf.ld_addr  = '0;
    sbIf.mem_ack  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkEq("rstMemReq", 64'(sbIf.mem_req), 64'd0);
    checkEq("rstEmpty", 64'(sbIf.empty), 64'd1);
    checkEq("rstCount", 64'(sbIf.count), 64'd0);
    checkEq("rstStReady", 64'(sbIf.st_ready), 64'd1);
    checkEq("rstLdHit", 64'(sbIf.ld_hit), 64'd0);
    checkEq("rstLdConflict", 64'(sbIf.ld_conflict), 64'd0);
    checkEq("rstMemAddr", 64'(sbIf.mem_addr), 64'd0);
    checkEq("rstMemData", 64'(sbIf.mem_data), 64'd0);
    checkEq("rstMemDsize", 64'(sbIf.mem_dsize), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single store with ack held high: one-cycle request.
    sbIf.mem_ack = 1'b1;
    push(32'h100, 32'hDEADBEEF, 2'b10);
    checkEq("singleReqEarly", 64'(sbIf.mem_req), 64'd0);
    tick();
    checkEq("singleReq", 64'(sbIf.mem_req), 64'd1);
    checkEq("singleAddr", 64'(sbIf.mem_addr), 64'h100);
    checkEq("singleData", 64'(sbIf.mem_data), 64'hDEADBEEF);
    tick();
    checkEq("singleReqDone", 64'(sbIf.mem_req), 64'd0);
    checkEq("singleEmpty", 64'(sbIf.empty), 64'd1);
    sbIf.mem_ack = 1'b0;

    // Fill to full, refused fifth push, in-order drain, then refill across the wrap.
    for (int i = 0; i < DEPTH; i++) push(32'h400 + 32'(i * 4), 32'hA000 + 32'(i), 2'(i % 3));
    checkEq("fullStReady", 64'(sbIf.st_ready), 64'd0);
    checkEq("fullCount", 64'(sbIf.count), 64'd4);
    push(32'h4F0, 32'hBAD, 2'b10);
    checkEq("fullIgnored", 64'(sbIf.count), 64'd4);
    drainAll();
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(i * 4), $urandom, 2'b10);
    drainAll();
    for (int i = 0; i < DEPTH; i++) push(32'h600 + 32'(i * 4), $urandom, 2'(i));
    drainAll();

    // Youngest word store forwards; a younger sub-word store turns it into a conflict.
    push(32'h200, 32'h11111111, 2'b10);
    push(32'h200, 32'h22222222, 2'b10);
`ifdef STORE_BUFFER_FWD_EN
    loadCheck("fwd", 32'h202, 1'b1, 32'h22222222, 1'b0);
`else
    loadCheck("fwd", 32'h202, 1'b0, 32'h0, 1'b1);
`endif
    loadCheck("noMatch", 32'h500, 1'b0, 32'h0, 1'b0);
    sbIf.ld_valid = 1'b0;
    push(32'h203, 32'h33, 2'b00);
    loadCheck("youngByte", 32'h200, 1'b0, 32'h0, 1'b1);
    sbIf.ld_valid = 1'b0;
    drainAll();

    // Byte store conflicts with a word load until it retires.
    push(32'h301, 32'hAB, 2'b00);
    loadCheck("byteHaz", 32'h300, 1'b0, 32'h0, 1'b1);
    tick();
    loadCheck("byteHazReq", 32'h300, 1'b0, 32'h0, 1'b1);
    drainAll();
    loadCheck("byteHazGone", 32'h300, 1'b0, 32'h0, 1'b0);
    sbIf.ld_valid = 1'b0;

    // Push and pop on the same edge keep count and order.
    push(32'h700, 32'h70, 2'b10);
    push(32'h704, 32'h71, 2'b10);
    checkEq("ppReq", 64'(sbIf.mem_req), 64'd1);
    sbIf.mem_ack = 1'b1;
    push(32'h708, 32'h72, 2'b01);
    checkEq("ppCount", 64'(sbIf.count), 64'd2);
    drainAll();

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) push(32'h800 + 32'(i * 4), 32'h80 + 32'(i), 2'b10);
    checkEq("midReq", 64'(sbIf.mem_req), 64'd1);
    reset = 1'b0;
    #1;
    checkEq("asyncReqDrop", 64'(sbIf.mem_req), 64'd0);
    checkEq("asyncCount", 64'(sbIf.count), 64'd0);
    expQ.delete();
    modelCount = 0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkEq("postRstEmpty", 64'(sbIf.empty), 64'd1);
    checkEq("postRstReq", 64'(sbIf.mem_req), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
